vx_mem_latency_pipe: RTL

//  Parametrised in-order memory response delay line for bench and memory-model use. Replaces the

---
 rtl/vx_mem_latency_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vx_mem_latency_pipe.sv
// In-order memory response delay line.
// Every accepted response is held for its own runtime latency and then
// released, strictly in arrival order, on a valid/ready output.
// Storage is a circular buffer of DEPTH entries. DEPTH need not be a power of two.
module vx_mem_latency_pipe #(
    parameter int DATA_WIDTH  = 512,
    parameter int TAG_WIDTH   = 8,
    parameter int DEPTH       = 16,
    parameter int MAX_LATENCY = 32,
    localparam int LW = $clog2(MAX_LATENCY + 1),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LW-1:0]         latency,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    input  logic                  out_ready,
    output logic [CW-1:0]         count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] MAX_LAT  = LW'(MAX_LATENCY);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q   [DEPTH];
    logic [LW-1:0]         timer_q [DEPTH];
    logic [LW-1:0]         timer_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [LW-1:0]         eff_lat;
    logic                  in_fire;
    logic                  out_fire;

    // in_ready looks only at registered occupancy, so a full buffer never
    // accepts in the same cycle that the head drains.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = valid_q[rd_ptr_q] && (timer_q[rd_ptr_q] == '0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];
    assign count     = count_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Clamp the requested latency to the range 1..MAX_LATENCY.
    always_comb begin
        eff_lat = latency;
        if (latency == '0) begin
            eff_lat = LW'(1);
        end else if (latency > MAX_LAT) begin
            eff_lat = MAX_LAT;
        end
    end

    // Next state for the pointers, the occupancy and the per-entry timer and valid bits.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;

        if (out_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
        if (in_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end

        case ({in_fire, out_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            timer_d[i] = timer_q[i];
            // Matured entries, including a stalled head, hold at zero.
            if (valid_q[i] && (timer_q[i] != '0)) begin
                timer_d[i] = timer_q[i] - 1'b1;
            end
            if (out_fire && (rd_ptr_q == PW'(i))) begin
                valid_d[i] = 1'b0;
            end
            // A newly written entry starts at eff-1 and does not decrement on its write edge.
            // Its earliest release is therefore eff edges after acceptance.
            if (in_fire && (wr_ptr_q == PW'(i))) begin
                timer_d[i] = eff_lat - 1'b1;
                valid_d[i] = 1'b1;
            end
        end
    end

    // Control state: reset discards everything that is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                timer_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Payload storage. It has no reset because the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            data_q[wr_ptr_q] <= in_data;
            tag_q[wr_ptr_q]  <= in_tag;
        end
    end

endmodule
